// File: rtl/ex_compute_if.sv
// Operand/result bundle between the EX-stage operand muxes and the compute core.
// Optional ALU_OVF_EN adds the signed-overflow flag alu_ovf.
interface ex_compute_if;
  logic               en;
  logic [3:0]         alu_op;
  logic signed [31:0] a;
  logic signed [31:0] b;
  logic [1:0]         branch_cond;
  logic [31:0]        last_pc;
  logic [1:0]         pc_inc;
  logic [31:0]        abs_addr;
  logic signed [31:0] branch_addr;
  logic signed [31:0] alu_result;
  logic               alu_zero;
  logic [1:0]         pc_inc_eff;
  logic [31:0]        next_pc;
  logic signed [31:0] alu_result_q;
  logic               alu_zero_q;
  logic [31:0]        next_pc_q;
`ifdef ALU_OVF_EN
  logic               alu_ovf;
`endif

  modport master (
    output en, alu_op, a, b, branch_cond, last_pc, pc_inc, abs_addr, branch_addr,
    input  alu_result, alu_zero, pc_inc_eff, next_pc, alu_result_q, alu_zero_q, next_pc_q
`ifdef ALU_OVF_EN
    , input alu_ovf
`endif
  );

  modport slave (
    input  en, alu_op, a, b, branch_cond, last_pc, pc_inc, abs_addr, branch_addr,
    output alu_result, alu_zero, pc_inc_eff, next_pc, alu_result_q, alu_zero_q, next_pc_q
`ifdef ALU_OVF_EN
    , output alu_ovf
`endif
  );
endinterface

// File: rtl/ex_compute_unit.sv
// EX-stage core: 32-bit ALU fused with zero-flag branch resolution and next-PC select,
// combinational results plus an EX/MEM capture register. ALU_OVF_EN enables alu_ovf.
module ex_compute_unit (
  input  logic         clk,
  input  logic         clr_n,
  ex_compute_if.slave  bus
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_SLTU = 4'd10;
  localparam logic [3:0] OP_LUI  = 4'd11;

  localparam logic [1:0] PC_NORMAL = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_STOP   = 2'b11;

  localparam logic [1:0] COND_BEQ = 2'b01;
  localparam logic [1:0] COND_BNE = 2'b10;

  logic signed [31:0] result;
  logic               zero;
  logic               taken;
  logic [1:0]         pc_eff;
  logic [31:0]        npc;
  logic [4:0]         shamt;

  logic signed [31:0] alu_result_p0;
  logic               alu_zero_p0;
  logic [31:0]        next_pc_p0;

  assign shamt = bus.b[4:0];

  always_comb begin
    result = '0;
    unique case (bus.alu_op)
      OP_ADD:  result = bus.a + bus.b;
      OP_SUB:  result = bus.a - bus.b;
      OP_AND:  result = bus.a & bus.b;
      OP_OR:   result = bus.a | bus.b;
      OP_XOR:  result = bus.a ^ bus.b;
      OP_NOR:  result = ~(bus.a | bus.b);
      OP_SLL:  result = bus.a << shamt;
      OP_SRL:  result = $signed($unsigned(bus.a) >> shamt);
      OP_SRA:  result = bus.a >>> shamt;
      OP_SLT:  result = {31'd0, (bus.a < bus.b)};
      OP_SLTU: result = {31'd0, ($unsigned(bus.a) < $unsigned(bus.b))};
      OP_LUI:  result = bus.b << 16;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

  // Branch resolution feeds PC steering in the same cycle as the ALU result.
  always_comb begin
    taken  = ((bus.branch_cond == COND_BEQ) && zero) ||
             ((bus.branch_cond == COND_BNE) && !zero);
    pc_eff = bus.pc_inc;
    if (bus.pc_inc == PC_BRANCH && !taken)
      pc_eff = PC_NORMAL;
    npc = bus.last_pc + 32'd1;
    unique case (pc_eff)
      PC_NORMAL: npc = bus.last_pc + 32'd1;
      PC_BRANCH: npc = bus.last_pc + 32'd1 + $unsigned(bus.branch_addr);
      PC_JUMP:   npc = bus.abs_addr;
      PC_STOP:   npc = bus.last_pc;
      default:   npc = bus.last_pc + 32'd1;
    endcase
  end

  assign bus.alu_result = result;
  assign bus.alu_zero   = zero;
  assign bus.pc_inc_eff = pc_eff;
  assign bus.next_pc    = npc;

`ifdef ALU_OVF_EN
  function automatic logic ovf_detect(input logic [3:0] op, input logic sa,
                                      input logic sb, input logic sr);
    logic ovf;
    ovf = 1'b0;
    if (op == OP_ADD)
      ovf = (sa == sb) && (sr != sa);
    else if (op == OP_SUB)
      ovf = (sa != sb) && (sr != sa);
    return ovf;
  endfunction

  assign bus.alu_ovf = ovf_detect(bus.alu_op, bus.a[31], bus.b[31], result[31]);
`endif

  // EX/MEM capture stage: clears asynchronously, loads only when en is high.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      alu_result_p0 <= '0;
      alu_zero_p0   <= 1'b0;
      next_pc_p0    <= '0;
    end else if (bus.en) begin
      alu_result_p0 <= result;
      alu_zero_p0   <= zero;
      next_pc_p0    <= npc;
    end
  end

  assign bus.alu_result_q = alu_result_p0;
  assign bus.alu_zero_q   = alu_zero_p0;
  assign bus.next_pc_q    = next_pc_p0;

endmodule

// File: tb/tb_ex_compute_unit.sv
// Scoreboard bench for ex_compute_unit: stimulus pushes expectations, a negedge monitor checks them.
module tb_ex_compute_unit;

  logic clk;
  logic clr_n;
  ex_compute_if bus ();

  ex_compute_unit dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          do_comb;
    bit          do_ovf;
    bit          do_reg;
    logic [31:0] res;
    logic        zero;
    logic [1:0]  eff;
    logic [31:0] npc;
    logic        ovf;
    logic [31:0] res_q;
    logic        zero_q;
    logic [31:0] npc_q;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
    end
  endtask

  // Monitor: checks every pending expectation away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.do_comb) begin
          chk({e.name, ".result"}, bus.alu_result, e.res);
          chk({e.name, ".zero"}, {31'd0, bus.alu_zero}, {31'd0, e.zero});
          chk({e.name, ".pc_eff"}, {30'd0, bus.pc_inc_eff}, {30'd0, e.eff});
          chk({e.name, ".next_pc"}, bus.next_pc, e.npc);
        end
`ifdef ALU_OVF_EN
        if (e.do_ovf)
          chk({e.name, ".ovf"}, {31'd0, bus.alu_ovf}, {31'd0, e.ovf});
`endif
        if (e.do_reg) begin
          chk({e.name, ".result_q"}, bus.alu_result_q, e.res_q);
          chk({e.name, ".zero_q"}, {31'd0, bus.alu_zero_q}, {31'd0, e.zero_q});
          chk({e.name, ".next_pc_q"}, bus.next_pc_q, e.npc_q);
        end
      end
    end
  end

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] cond, input logic [31:0] lpc, input logic [1:0] inc,
                       input logic [31:0] abs_a, input logic [31:0] br);
    bus.alu_op      = op;
    bus.a           = a;
    bus.b           = b;
    bus.branch_cond = cond;
    bus.last_pc     = lpc;
    bus.pc_inc      = inc;
    bus.abs_addr    = abs_a;
    bus.branch_addr = br;
  endtask

  task automatic push_comb(input string nm, input logic [31:0] res, input logic zero,
                           input logic [1:0] eff, input logic [31:0] npc,
                           input bit do_ovf, input logic ovf);
    exp_t e;
    e = '{name: nm, do_comb: 1'b1, do_ovf: do_ovf, do_reg: 1'b0, res: res, zero: zero,
          eff: eff, npc: npc, ovf: ovf, res_q: '0, zero_q: 1'b0, npc_q: '0};
    exp_q.push_back(e);
  endtask

  task automatic push_reg(input string nm, input logic [31:0] rq, input logic zq,
                          input logic [31:0] pq);
    exp_t e;
    e = '{name: nm, do_comb: 1'b0, do_ovf: 1'b0, do_reg: 1'b1, res: '0, zero: 1'b0,
          eff: 2'b00, npc: '0, ovf: 1'b0, res_q: rq, zero_q: zq, npc_q: pq};
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr_n  = 1'b0;
    bus.en = 1'b0;
    drive(4'd0, 32'd0, 32'd0, 2'b00, 32'h10, 2'b00, 32'd0, 32'd0);
    step();
    push_reg("reset", 32'd0, 1'b0, 32'd0);
    step();
    clr_n = 1'b1;

    // ALU operations, pc_inc NORMAL from last_pc 0x10
    step(); drive(4'd0, 32'hFFFF_FFFF, 32'd1, 2'b00, 32'h10, 2'b00, 32'h999, 32'h5);
    push_comb("add_wrap", 32'd0, 1'b1, 2'b00, 32'h11, 1'b1, 1'b0);
    step(); drive(4'd0, 32'h7FFF_FFFF, 32'd1, 2'b00, 32'h10, 2'b00, 32'd0, 32'd0);
    push_comb("add_ovf", 32'h8000_0000, 1'b0, 2'b00, 32'h11, 1'b1, 1'b1);
    step(); drive(4'd1, 32'h8000_0000, 32'd1, 2'b00, 32'h10, 2'b00, 32'd0, 32'd0);
    push_comb("sub_ovf", 32'h7FFF_FFFF, 1'b0, 2'b00, 32'h11, 1'b1, 1'b1);
    step(); drive(4'd9, 32'hFFFF_FFFF, 32'd1, 2'b00, 32'h10, 2'b00, 32'd0, 32'd0);
    push_comb("slt", 32'd1, 1'b0, 2'b00, 32'h11, 1'b1, 1'b0);
    step(); drive(4'd10, 32'hFFFF_FFFF, 32'd1, 2'b00, 32'h10, 2'b00, 32'd0, 32'd0);
    push_comb("sltu", 32'd0, 1'b1, 2'b00, 32'h11, 1'b1, 1'b0);
    step(); drive(4'd8, 32'h8000_0000, 32'd4, 2'b00, 32'h10, 2'b00, 32'd0, 32'd0);
    push_comb("sra", 32'hF800_0000, 1'b0, 2'b00, 32'h11, 1'b1, 1'b0);
    step(); drive(4'd7, 32'h8000_0000, 32'd4, 2'b00, 32'h10, 2'b00, 32'd0, 32'd0);
    push_comb("srl", 32'h0800_0000, 1'b0, 2'b00, 32'h11, 1'b0, 1'b0);
    step(); drive(4'd6, 32'd1, 32'h21, 2'b00, 32'h10, 2'b00, 32'd0, 32'd0);
    push_comb("sll_mask", 32'd2, 1'b0, 2'b00, 32'h11, 1'b0, 1'b0);
    step(); drive(4'd11, 32'hDEAD, 32'h1234, 2'b00, 32'h10, 2'b00, 32'd0, 32'd0);
    push_comb("lui", 32'h1234_0000, 1'b0, 2'b00, 32'h11, 1'b0, 1'b0);
    step(); drive(4'd2, 32'hF0F0, 32'hFF00, 2'b00, 32'h10, 2'b00, 32'd0, 32'd0);
    push_comb("and", 32'hF000, 1'b0, 2'b00, 32'h11, 1'b0, 1'b0);
    step(); drive(4'd3, 32'hF0F0, 32'hFF00, 2'b00, 32'h10, 2'b00, 32'd0, 32'd0);
    push_comb("or", 32'hFFF0, 1'b0, 2'b00, 32'h11, 1'b0, 1'b0);
    step(); drive(4'd4, 32'hF0F0, 32'hFF00, 2'b00, 32'h10, 2'b00, 32'd0, 32'd0);
    push_comb("xor", 32'h0FF0, 1'b0, 2'b00, 32'h11, 1'b0, 1'b0);
    step(); drive(4'd5, 32'd0, 32'd0, 2'b00, 32'h10, 2'b00, 32'd0, 32'd0);
    push_comb("nor", 32'hFFFF_FFFF, 1'b0, 2'b00, 32'h11, 1'b0, 1'b0);
    step(); drive(4'd12, 32'h55, 32'h66, 2'b00, 32'h10, 2'b00, 32'd0, 32'd0);
    push_comb("op12", 32'd0, 1'b1, 2'b00, 32'h11, 1'b1, 1'b0);

    // Branch resolution and PC modes
    step(); drive(4'd1, 32'd5, 32'd5, 2'b01, 32'h10, 2'b01, 32'h400, 32'hFFFF_FFFE);
    push_comb("beq_taken", 32'd0, 1'b1, 2'b01, 32'h0F, 1'b0, 1'b0);
    step(); drive(4'd1, 32'd5, 32'd6, 2'b01, 32'h10, 2'b01, 32'h400, 32'hFFFF_FFFE);
    push_comb("beq_not", 32'hFFFF_FFFF, 1'b0, 2'b00, 32'h11, 1'b0, 1'b0);
    step(); drive(4'd1, 32'd5, 32'd6, 2'b10, 32'h10, 2'b01, 32'h400, 32'd3);
    push_comb("bne_taken", 32'hFFFF_FFFF, 1'b0, 2'b01, 32'h14, 1'b0, 1'b0);
    step(); drive(4'd1, 32'd5, 32'd5, 2'b10, 32'h10, 2'b01, 32'h400, 32'd3);
    push_comb("bne_not", 32'd0, 1'b1, 2'b00, 32'h11, 1'b0, 1'b0);
    step(); drive(4'd1, 32'd5, 32'd5, 2'b11, 32'h10, 2'b01, 32'h400, 32'd3);
    push_comb("cond_rsvd", 32'd0, 1'b1, 2'b00, 32'h11, 1'b0, 1'b0);
    step(); drive(4'd1, 32'd5, 32'd5, 2'b01, 32'h10, 2'b00, 32'h400, 32'd3);
    push_comb("normal_beq", 32'd0, 1'b1, 2'b00, 32'h11, 1'b0, 1'b0);
    step(); drive(4'd1, 32'd5, 32'd6, 2'b00, 32'h10, 2'b11, 32'h400, 32'd3);
    push_comb("stop", 32'hFFFF_FFFF, 1'b0, 2'b11, 32'h10, 1'b0, 1'b0);

    // Registered path: capture a JUMP, then hold, then async clear
    step(); drive(4'd0, 32'd5, 32'd6, 2'b00, 32'h10, 2'b10, 32'h400, 32'd3);
    bus.en = 1'b1;
    push_comb("jump", 32'd11, 1'b0, 2'b10, 32'h400, 1'b1, 1'b0);
    step(); bus.en = 1'b0;
    push_reg("capture", 32'd11, 1'b0, 32'h400);
    drive(4'd0, 32'hFFFF_FFFF, 32'd1, 2'b00, 32'h20, 2'b00, 32'd0, 32'd0);
    step();
    push_comb("hold_comb", 32'd0, 1'b1, 2'b00, 32'h21, 1'b0, 1'b0);
    push_reg("hold", 32'd11, 1'b0, 32'h400);
    step(); clr_n = 1'b0;
    push_reg("clr_async", 32'd0, 1'b0, 32'd0);
    push_comb("clr_comb", 32'd0, 1'b1, 2'b00, 32'h21, 1'b0, 1'b0);
    step(); bus.en = 1'b1;
    push_reg("clr_en_held", 32'd0, 1'b0, 32'd0);
    step(); clr_n = 1'b1;
    step(); bus.en = 1'b0;
    push_reg("recapture", 32'd0, 1'b1, 32'h21);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
